ilowx_rr_arbiter: RTL and testbench

//  Parametrised N-channel front end for the instruction lower-level (ilowX) memory port.

---
 rtl/ilowx_rr_arbiter_pkg.sv | 38 +++
 rtl/ilowx_rr_arbiter_rr_pick.sv | 48 ++++
 rtl/ilowx_rr_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_ilowx_rr_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ilowx_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// ilowx_rr_arbiter_pkg
//   Shared definitions for the ilowX fetch-port arbiter and its round-robin
//   picker. The picker is also meant to be reused by the dcache arbiter, so the
//   width helpers live here rather than inside either module.
//
//   Contents:
//     ILX_ARB_CH    default number of fetch channels on the ilowX port
//     ILX_XLEN      default address width
//     ILX_BLK_SIZE  default cache block width in bits
//     arb_state_e   arbiter FSM states
//     blk_ofs()     number of byte-offset bits inside one cache block
//     id_width()    width of a channel index (at least 1 bit)
// -----------------------------------------------------------------------------
package ilowx_rr_arbiter_pkg;

  localparam int ILX_ARB_CH   = 2;
  localparam int ILX_XLEN     = 32;
  localparam int ILX_BLK_SIZE = 128;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,  // waiting for a channel request
    REQ      = 2'd1,  // presenting the request on the lower port
    WAIT_RES = 2'd2,  // request accepted, waiting for the block
    RESP     = 2'd3   // block registered, offering it to the granted channel
  } arb_state_e;

  // Byte-offset bits within one block; BLK_SIZE is a power of two >= 8.
  function automatic int blk_ofs(input int blk_size);
    return $clog2(blk_size / 8);
  endfunction

  // A single channel still needs a 1-bit index to keep port widths legal.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : ilowx_rr_arbiter_pkg

// File: rtl/ilowx_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// ilowx_rr_arbiter_rr_pick
//   Combinational round-robin priority picker. Starting at ptr and scanning
//   upward (wrapping from N-1 back to 0), returns the index of the first set
//   bit of req. Purely combinational; the caller owns the pointer register.
//
//   Parameters:
//     N    number of requesters (>= 1)
//     IDW  index width, normally id_width(N)
//   Ports:
//     req    in   N     request vector
//     ptr    in   IDW   highest-priority index this cycle (must be < N)
//     valid  out  1     at least one request is set
//     idx    out  IDW   winning index (0 when valid = 0)
// -----------------------------------------------------------------------------
module ilowx_rr_arbiter_rr_pick
  import ilowx_rr_arbiter_pkg::*;
#(
  parameter int N   = ILX_ARB_CH,
  parameter int IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  int j;

  // The scan runs from the farthest offset down to offset 0, so the candidate
  // closest to ptr is written last and wins. No priority chain is needed.
  // NOTE: every output of a combinational block gets a default at the top so
  // that no path leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int off = N - 1; off >= 0; off--) begin
      j = int'(ptr) + off;
      if (j >= N) j = j - N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IDW'(j);
      end
    end
  end

endmodule : ilowx_rr_arbiter_rr_pick

// File: rtl/ilowx_rr_arbiter.sv
// -----------------------------------------------------------------------------
// ilowx_rr_arbiter
//   Front end of the instruction lower-level (ilowX) memory port. Merges
//   NUM_CH fetch requesters (icache miss path, prefetcher, uncached fetch)
//   onto a single ilowX port with fair round-robin arbitration. Exactly one
//   transaction is outstanding on the lower port; the returned block is
//   registered and steered back to the channel that held the grant.
//
//   Transaction flow: IDLE (grant + latch) -> REQ (lx request handshake)
//   -> WAIT_RES (lx response handshake) -> RESP (channel response handshake)
//   -> IDLE. Best case: accept@0, lx req@1, lx res@2, ch res@3, with one IDLE
//   bubble between back-to-back transactions.
//
//   Parameters:
//     NUM_CH    number of requesting channels (>= 1)
//     XLEN      address width
//     BLK_SIZE  cache block width in bits (power of two, >= 8)
//   Ports:
//     clk_i              in   1            clock, rising edge
//     rst_ni             in   1            asynchronous active-low reset
//     ch_req_valid_i     in   NUM_CH       per-channel request valid
//     ch_req_addr_i      in   NUM_CH*XLEN  per-channel request address
//     ch_req_uncached_i  in   NUM_CH       per-channel uncached flag
//     ch_req_ready_o     out  NUM_CH       request accepted (one-hot or 0)
//     ch_res_valid_o     out  NUM_CH       response valid (one-hot or 0)
//     ch_res_ready_i     in   NUM_CH       channel accepts its response
//     ch_res_blk_o       out  BLK_SIZE     response block, shared
//     lx_req_valid_o     out  1            lower-level request valid
//     lx_req_ready_i     in   1            lower level accepts request
//     lx_req_addr_o      out  XLEN         lower-level request address
//     lx_req_uncached_o  out  1            lower-level uncached flag
//     lx_res_valid_i     in   1            lower-level response valid
//     lx_res_ready_o     out  1            arbiter accepts lower-level response
//     lx_res_blk_i       in   BLK_SIZE     lower-level response block
//     busy_o             out  1            state != IDLE
//     grant_id_o         out  IDW          channel holding the current grant
// -----------------------------------------------------------------------------
module ilowx_rr_arbiter
  import ilowx_rr_arbiter_pkg::*;
#(
  parameter int NUM_CH   = ILX_ARB_CH,
  parameter int XLEN     = ILX_XLEN,
  parameter int BLK_SIZE = ILX_BLK_SIZE,
  localparam int IDW     = id_width(NUM_CH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // channel side
  input  logic [NUM_CH-1:0]      ch_req_valid_i,
  input  logic [NUM_CH*XLEN-1:0] ch_req_addr_i,
  input  logic [NUM_CH-1:0]      ch_req_uncached_i,
  output logic [NUM_CH-1:0]      ch_req_ready_o,
  output logic [NUM_CH-1:0]      ch_res_valid_o,
  input  logic [NUM_CH-1:0]      ch_res_ready_i,
  output logic [BLK_SIZE-1:0]    ch_res_blk_o,
  // ilowX side
  output logic                   lx_req_valid_o,
  input  logic                   lx_req_ready_i,
  output logic [XLEN-1:0]        lx_req_addr_o,
  output logic                   lx_req_uncached_o,
  input  logic                   lx_res_valid_i,
  output logic                   lx_res_ready_o,
  input  logic [BLK_SIZE-1:0]    lx_res_blk_i,
  // status
  output logic                   busy_o,
  output logic [IDW-1:0]         grant_id_o
);

  localparam int BLK_OFS = blk_ofs(BLK_SIZE);

  // Clears the byte offset within a block for cached requests.
  localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << BLK_OFS;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_e            state;
  logic [IDW-1:0]        rr_ptr;
  logic [IDW-1:0]        grant_id;
  logic [XLEN-1:0]       addr_q;
  logic                  uncached_q;
  logic [BLK_SIZE-1:0]   blk_q;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic                  pick_valid;
  logic [IDW-1:0]        pick_idx;
  logic [XLEN-1:0]       pick_addr;
  logic                  pick_uncached;
  logic [XLEN-1:0]       pick_addr_lx;
  logic [IDW-1:0]        rr_ptr_next;

  ilowx_rr_arbiter_rr_pick #(
    .N   (NUM_CH),
    .IDW (IDW)
  ) u_rr_pick (
    .req   (ch_req_valid_i),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign pick_addr     = ch_req_addr_i[pick_idx*XLEN +: XLEN];
  assign pick_uncached = ch_req_uncached_i[pick_idx];

  // Uncached fetches keep their exact byte address; cached ones fetch a
  // whole block, so the lower level sees the block-aligned address.
  assign pick_addr_lx  = pick_uncached ? pick_addr : (pick_addr & ALIGN_MASK);

  // The pointer moves just past the channel that was served, which bounds
  // any channel's wait to NUM_CH-1 grants. With NUM_CH=1 it stays at 0.
  assign rr_ptr_next   = (grant_id == IDW'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;

  // ---------------------------------------------------------------------------
  // FSM and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values and the block order cannot matter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      addr_q     <= '0;
      uncached_q <= 1'b0;
      blk_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Request inputs are sampled only here; after the accept the
          // granted channel may change or drop them freely.
          if (pick_valid) begin
            grant_id   <= pick_idx;
            addr_q     <= pick_addr_lx;
            uncached_q <= pick_uncached;
            state      <= REQ;
          end
        end
        REQ: begin
          if (lx_req_ready_i) state <= WAIT_RES;
        end
        WAIT_RES: begin
          if (lx_res_valid_i) begin
            blk_q <= lx_res_blk_i;
            state <= RESP;
          end
        end
        RESP: begin
          // Only the granted channel's ready completes the transaction.
          if (ch_res_ready_i[grant_id]) begin
            rr_ptr <= rr_ptr_next;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Handshake strobes decode straight from the state register, so they are
  // glitch-free apart from ch_req_ready_o, which must answer in the same
  // cycle as the request.
  always_comb begin
    ch_req_ready_o = '0;
    if (state == IDLE && pick_valid) ch_req_ready_o[pick_idx] = 1'b1;
  end

  always_comb begin
    ch_res_valid_o = '0;
    if (state == RESP) ch_res_valid_o[grant_id] = 1'b1;
  end

  assign ch_res_blk_o      = blk_q;
  assign lx_req_valid_o    = (state == REQ);
  assign lx_req_addr_o     = addr_q;
  assign lx_req_uncached_o = uncached_q;

  // Responses are only taken in WAIT_RES; a stray or stale response in any
  // other state is left for the lower level to hold or drain.
  assign lx_res_ready_o    = (state == WAIT_RES);

  assign busy_o            = (state != IDLE);
  assign grant_id_o        = grant_id;

endmodule : ilowx_rr_arbiter

// File: tb/tb_ilowx_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ilowx_rr_arbiter
//   Directed self-checking bench for ilowx_rr_arbiter with NUM_CH=2, XLEN=32,
//   BLK_SIZE=128. Each transaction is driven through the full handshake
//   sequence and compared against hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_ilowx_rr_arbiter;

  localparam int NUM_CH   = 2;
  localparam int XLEN     = 32;
  localparam int BLK_SIZE = 128;

  logic                   clk_i;
  logic                   rst_ni;
  logic [NUM_CH-1:0]      ch_req_valid;
  logic [NUM_CH*XLEN-1:0] ch_req_addr;
  logic [NUM_CH-1:0]      ch_req_uncached;
  logic [NUM_CH-1:0]      ch_req_ready;
  logic [NUM_CH-1:0]      ch_res_valid;
  logic [NUM_CH-1:0]      ch_res_ready;
  logic [BLK_SIZE-1:0]    ch_res_blk;
  logic                   lx_req_valid;
  logic                   lx_req_ready;
  logic [XLEN-1:0]        lx_req_addr;
  logic                   lx_req_uncached;
  logic                   lx_res_valid;
  logic                   lx_res_ready;
  logic [BLK_SIZE-1:0]    lx_res_blk;
  logic                   busy;
  logic                   grant_id;

  int n_vec;
  int n_err;

  ilowx_rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .XLEN     (XLEN),
    .BLK_SIZE (BLK_SIZE)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .ch_req_valid_i    (ch_req_valid),
    .ch_req_addr_i     (ch_req_addr),
    .ch_req_uncached_i (ch_req_uncached),
    .ch_req_ready_o    (ch_req_ready),
    .ch_res_valid_o    (ch_res_valid),
    .ch_res_ready_i    (ch_res_ready),
    .ch_res_blk_o      (ch_res_blk),
    .lx_req_valid_o    (lx_req_valid),
    .lx_req_ready_i    (lx_req_ready),
    .lx_req_addr_o     (lx_req_addr),
    .lx_req_uncached_o (lx_req_uncached),
    .lx_res_valid_i    (lx_res_valid),
    .lx_res_ready_o    (lx_res_ready),
    .lx_res_blk_i      (lx_res_blk),
    .busy_o            (busy),
    .grant_id_o        (grant_id)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, "_busy"},      busy,            1'b0);
    check({tag, "_gid"},       grant_id,        1'b0);
    check({tag, "_lxreqv"},    lx_req_valid,    1'b0);
    check({tag, "_lxaddr"},    lx_req_addr,     32'h0);
    check({tag, "_lxunc"},     lx_req_uncached, 1'b0);
    check({tag, "_lxresrdy"},  lx_res_ready,    1'b0);
    check({tag, "_chresv"},    ch_res_valid,    2'b00);
    check({tag, "_chblk"},     ch_res_blk,      128'h0);
  endtask

  // One complete transaction for channel ch. 'hold' keeps other channels
  // requesting throughout, to show no second accept happens while busy.
  task automatic do_txn(input int ch, input logic [31:0] addr, input logic unc,
                        input logic [127:0] blk, input logic [31:0] exp_addr,
                        input int req_stall, input int res_stall,
                        input logic [1:0] hold);
    logic [1:0] me;
    me = 2'b01 << ch;
    ch_req_addr[ch*32 +: 32] = addr;
    ch_req_uncached[ch]      = unc;
    ch_req_valid             = me | hold;
    #1;
    check("grant_ready", ch_req_ready, me);
    check("grant_idle",  busy,         1'b0);
    tick();
    // Corrupt the granted channel's inputs: they must be ignored now.
    ch_req_valid             = hold;
    ch_req_addr[ch*32 +: 32] = 32'hDEAD_BEEF;
    ch_req_uncached[ch]      = ~unc;
    #1;
    check("req_valid",   lx_req_valid,    1'b1);
    check("req_addr",    lx_req_addr,     exp_addr);
    check("req_unc",     lx_req_uncached, unc);
    check("req_gid",     grant_id,        ch[0]);
    check("req_busy",    busy,            1'b1);
    check("req_noacc",   ch_req_ready,    2'b00);
    check("req_resrdy",  lx_res_ready,    1'b0);
    for (int i = 0; i < req_stall; i++) begin
      tick();
      check("stall_req_valid", lx_req_valid, 1'b1);
      check("stall_req_addr",  lx_req_addr,  exp_addr);
      check("stall_noacc",     ch_req_ready, 2'b00);
      check("stall_busy",      busy,         1'b1);
    end
    lx_req_ready = 1'b1;
    tick();
    lx_req_ready = 1'b0;
    #1;
    check("wait_resrdy", lx_res_ready, 1'b1);
    check("wait_reqv",   lx_req_valid, 1'b0);
    check("wait_chresv", ch_res_valid, 2'b00);
    lx_res_valid = 1'b1;
    lx_res_blk   = blk;
    tick();
    lx_res_valid = 1'b0;
    lx_res_blk   = ~blk;
    #1;
    check("resp_valid",  ch_res_valid, me);
    check("resp_blk",    ch_res_blk,   blk);
    check("resp_resrdy", lx_res_ready, 1'b0);
    // Only the other channel's ready during the stall: must be ignored.
    ch_res_ready = ~me;
    for (int i = 0; i < res_stall; i++) begin
      tick();
      check("stall_resp_valid", ch_res_valid, me);
      check("stall_resp_blk",   ch_res_blk,   blk);
      check("stall_resp_busy",  busy,         1'b1);
      check("stall_resp_noacc", ch_req_ready, 2'b00);
    end
    ch_res_ready = me;
    tick();
    ch_res_ready = 2'b00;
    #1;
    check("done_resv", ch_res_valid, 2'b00);
    check("done_busy", busy,         1'b0);
  endtask

  initial begin
    n_vec           = 0;
    n_err           = 0;
    rst_ni          = 1'b1;
    ch_req_valid    = '0;
    ch_req_addr     = '0;
    ch_req_uncached = '0;
    ch_res_ready    = '0;
    lx_req_ready    = 1'b0;
    lx_res_valid    = 1'b0;
    lx_res_blk      = '0;

    #2;
    apply_reset();
    check_all_idle("rst");
    check("rst_chreqrdy", ch_req_ready, 2'b00);

    // 1. Cached single request, block-aligned address, 3-cycle latency.
    do_txn(0, 32'h0000_1234, 1'b0, {16{8'hA5}}, 32'h0000_1230, 0, 0, 2'b00);

    // 2. Uncached request: address passes through unchanged.
    do_txn(1, 32'h8000_0006, 1'b1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
           32'h8000_0006, 0, 0, 2'b00);

    // 3. Fairness from a fresh reset with both channels continuously valid.
    apply_reset();
    do_txn(0, 32'h0000_2010, 1'b0, 128'h11, 32'h0000_2010, 0, 0, 2'b11);
    do_txn(1, 32'h0000_301F, 1'b0, 128'h22, 32'h0000_3010, 0, 0, 2'b11);
    do_txn(0, 32'h0000_4008, 1'b0, 128'h33, 32'h0000_4000, 0, 0, 2'b11);
    do_txn(1, 32'h0000_5001, 1'b1, 128'h44, 32'h0000_5001, 0, 0, 2'b11);

    // 4. Stalls on both handshakes with ch1 requesting the whole time.
    do_txn(0, 32'h1234_567F, 1'b0, {4{32'hCAFE_F00D}}, 32'h1234_5670, 5, 4, 2'b10);

    // 5. Reset while waiting for the lower-level response.
    ch_req_valid           = 2'b10;
    ch_req_addr[32 +: 32]  = 32'h0000_0ABC;
    ch_req_uncached        = 2'b00;
    #1;
    check("rst5_grant", ch_req_ready, 2'b10);
    tick();
    ch_req_valid = 2'b00;
    lx_req_ready = 1'b1;
    tick();
    lx_req_ready = 1'b0;
    #1;
    check("rst5_wait", lx_res_ready, 1'b1);
    rst_ni = 1'b0;
    #1;
    check_all_idle("rst5");
    check("rst5_chreqrdy", ch_req_ready, 2'b00);
    tick();
    rst_ni = 1'b1;
    #1;
    do_txn(0, 32'h0000_00F0, 1'b0, 128'h55, 32'h0000_00F0, 0, 0, 2'b10);
    ch_req_valid = 2'b00;

    // 6. Spurious lower-level response while IDLE.
    lx_res_valid = 1'b1;
    lx_res_blk   = {8{16'hBAD0}};
    #1;
    check("spur_resrdy", lx_res_ready, 1'b0);
    check("spur_resv",   ch_res_valid, 2'b00);
    tick();
    check("spur_busy",   busy,         1'b0);
    check("spur_resv2",  ch_res_valid, 2'b00);
    check("spur_blk",    ch_res_blk,   128'h55);
    lx_res_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ilowx_rr_arbiter
